// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions for the result stage: opcodes, flag bit indices,
// per-class PSR masks and the opcode-class decode.
package alu_result_stage_pkg;

   localparam int FLAG_N = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 4;

   localparam logic [4:0] MASK_NONE = 5'b00000;
   localparam logic [4:0] MASK_UNS  = (5'b00001 << FLAG_C) | (5'b00001 << FLAG_Z);
   localparam logic [4:0] MASK_SGN  = (5'b00001 << FLAG_F) | (5'b00001 << FLAG_Z);
   localparam logic [4:0] MASK_CMP  = (5'b00001 << FLAG_N) | (5'b00001 << FLAG_L) | (5'b00001 << FLAG_Z);
   localparam logic [4:0] MASK_LOG  = (5'b00001 << FLAG_Z);

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_ADDU   = 8'h01;
   localparam logic [7:0] OP_ADDUI  = 8'h02;
   localparam logic [7:0] OP_ADDCU  = 8'h03;
   localparam logic [7:0] OP_ADDCUI = 8'h04;
   localparam logic [7:0] OP_ADD    = 8'h05;
   localparam logic [7:0] OP_ADDI   = 8'h06;
   localparam logic [7:0] OP_ADDC   = 8'h07;
   localparam logic [7:0] OP_ADDCI  = 8'h08;
   localparam logic [7:0] OP_SUB    = 8'h09;
   localparam logic [7:0] OP_SUBI   = 8'h0A;
   localparam logic [7:0] OP_CMP    = 8'h0B;
   localparam logic [7:0] OP_CMPI   = 8'h0C;
   localparam logic [7:0] OP_CMPU   = 8'h0D;
   localparam logic [7:0] OP_CMPUI  = 8'h0E;
   localparam logic [7:0] OP_AND    = 8'h10;
   localparam logic [7:0] OP_ANDI   = 8'h11;
   localparam logic [7:0] OP_OR     = 8'h12;
   localparam logic [7:0] OP_ORI    = 8'h13;
   localparam logic [7:0] OP_XOR    = 8'h14;
   localparam logic [7:0] OP_XORI   = 8'h15;
   localparam logic [7:0] OP_NOT    = 8'h16;
   localparam logic [7:0] OP_LSH    = 8'h20;
   localparam logic [7:0] OP_LSHI   = 8'h21;
   localparam logic [7:0] OP_RSH    = 8'h22;
   localparam logic [7:0] OP_RSHI   = 8'h23;
   localparam logic [7:0] OP_ALSH   = 8'h24;
   localparam logic [7:0] OP_ALSHI  = 8'h25;
   localparam logic [7:0] OP_ARSH   = 8'h26;
   localparam logic [7:0] OP_ARSHI  = 8'h27;

   typedef struct packed {
      logic [4:0] mask;
      logic       we;
   } op_class_t;

   function automatic op_class_t op_decode(input logic [7:0] op);
      op_class_t c;
      c.mask = MASK_NONE;
      c.we   = 1'b0;
      case (op)
         OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
            c.mask = MASK_UNS;
            c.we   = 1'b1;
         end
         OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI, OP_SUB, OP_SUBI: begin
            c.mask = MASK_SGN;
            c.we   = 1'b1;
         end
         OP_CMP, OP_CMPI, OP_CMPU, OP_CMPUI: begin
            c.mask = MASK_CMP;
            c.we   = 1'b0;
         end
         OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_NOT: begin
            c.mask = MASK_LOG;
            c.we   = 1'b1;
         end
         OP_LSH, OP_LSHI, OP_RSH, OP_RSHI, OP_ALSH, OP_ALSHI, OP_ARSH, OP_ARSHI: begin
            c.mask = MASK_NONE;
            c.we   = 1'b1;
         end
         default: begin
            c.mask = MASK_NONE;
            c.we   = 1'b0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_result_stage_skid_fifo2.sv
// Two-entry skid FIFO with valid/ready on both sides. The head register drives
// the output and holds its last value once the buffer drains.
module alu_result_stage_skid_fifo2 #(
   parameter int W     = 21,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

   logic [1:0]   count_q, count_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_ready_q, in_ready_d;
   logic         push_s, pop_s;

   assign push_s = in_valid_i & in_ready_q;
   assign pop_s  = (count_q != 2'd0) & out_ready_i;

   // Occupancy and entry movement; head always holds the oldest entry.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case ({push_s, pop_s})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) head_d = in_data_i;
            else                 skid_d = in_data_i;
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            if (count_q == 2'd2) head_d = skid_q;
            else                 head_d = head_q;
         end
         // Simultaneous push and pop is only possible with exactly one entry.
         2'b11:   head_d  = in_data_i;
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < FULL_COUNT);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         count_q    <= count_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute/writeback boundary behind the ALU: buffers results for writeback,
// maintains the PSR from per-opcode flag masks and feeds carry back to the ALU.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [7:0]        in_opcode_i,
   input  logic [DATA_W-1:0] in_result_i,
   input  logic [4:0]        in_flags_i,
   input  logic [REG_AW-1:0] in_dest_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              wb_we_o,
   output logic [REG_AW-1:0] wb_dest_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [4:0]        psr_o,
   output logic              carry_to_alu_o,
   input  logic              psr_wr_en_i,
   input  logic [4:0]        psr_wr_data_i
);

   localparam int ENTRY_W = 1 + REG_AW + DATA_W;

   op_class_t          cls_s;
   logic               accept_s;
   logic [DATA_W-1:0]  store_data_s;
   logic [ENTRY_W-1:0] entry_in_s, entry_out_s;
   logic [4:0]         psr_q, psr_d;

   assign cls_s    = op_decode(in_opcode_i);
   assign accept_s = in_valid_i & in_ready_o;

   // Non-writing entries store zero so an undriven result never reaches wb_data.
   assign store_data_s = cls_s.we ? in_result_i : '0;
   assign entry_in_s   = {cls_s.we, in_dest_i, store_data_s};

   alu_result_stage_skid_fifo2 #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (entry_in_s),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (entry_out_s)
   );

   assign {wb_we_o, wb_dest_o, wb_data_o} = entry_out_s;

   // PSR update on accept so a dependent op in the next cycle sees the new carry.
   always_comb begin
      psr_d = psr_q;
      if (psr_wr_en_i) begin
         psr_d = psr_wr_data_i;
      end else if (accept_s) begin
         psr_d = (psr_q & ~cls_s.mask) | (in_flags_i & cls_s.mask);
      end else begin
         psr_d = psr_q;
      end
   end

   // PSR register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) psr_q <= 5'b00000;
      else        psr_q <= psr_d;
   end

   assign psr_o          = psr_q;
   assign carry_to_alu_o = psr_q[FLAG_C];

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and pseudo-random bench for alu_result_stage with a reference
// PSR model and a queue of expected writeback entries.
module tb_alu_result_stage;
   import alu_result_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid, in_ready;
   logic [7:0]  in_opcode;
   logic [15:0] in_result;
   logic [4:0]  in_flags;
   logic [3:0]  in_dest;
   logic        out_valid, out_ready;
   logic        wb_we;
   logic [3:0]  wb_dest;
   logic [15:0] wb_data;
   logic [4:0]  psr;
   logic        carry;
   logic        psr_wr_en;
   logic [4:0]  psr_wr_data;

   typedef struct packed {
      logic        we;
      logic [3:0]  dest;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          mcount;
   logic [4:0]  mpsr;
   logic [4:0]  hold;
   int          n_asserts = 0;
   int          n_fail = 0;
   logic [7:0]  ops [0:11];

   always #5 clk = ~clk;

   alu_result_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_opcode_i    (in_opcode),
      .in_result_i    (in_result),
      .in_flags_i     (in_flags),
      .in_dest_i      (in_dest),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .wb_we_o        (wb_we),
      .wb_dest_o      (wb_dest),
      .wb_data_o      (wb_data),
      .psr_o          (psr),
      .carry_to_alu_o (carry),
      .psr_wr_en_i    (psr_wr_en),
      .psr_wr_data_i  (psr_wr_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {wb_we, mask} for each opcode class, written from the opcode table.
   function automatic logic [5:0] ref_class(input logic [7:0] op);
      case (op)
         OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI:                  ref_class = {1'b1, 5'b11000};
         OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI, OP_SUB, OP_SUBI:     ref_class = {1'b1, 5'b10100};
         OP_CMP, OP_CMPI, OP_CMPU, OP_CMPUI:                      ref_class = {1'b0, 5'b10011};
         OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_NOT: ref_class = {1'b1, 5'b10000};
         OP_LSH, OP_LSHI, OP_RSH, OP_RSHI,
         OP_ALSH, OP_ALSHI, OP_ARSH, OP_ARSHI:                    ref_class = {1'b1, 5'b00000};
         default:                                                 ref_class = {1'b0, 5'b00000};
      endcase
   endfunction

   task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] res,
                        input logic [4:0] fl, input logic [3:0] d);
      in_valid  = v;
      in_opcode = op;
      in_result = res;
      in_flags  = fl;
      in_dest   = d;
   endtask

   // Check current outputs against the model, then advance model and DUT one cycle.
   task automatic tick();
      logic [5:0] cls;
      bit         acc, pop;
      exp_t       e;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (mcount < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (mcount != 0)});
      chk("psr", {27'd0, psr}, {27'd0, mpsr});
      chk("carry", {31'd0, carry}, {31'd0, mpsr[3]});
      if (mcount != 0 && sb.size() != 0) begin
         e = sb[0];
         chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
         chk("wb_dest", {28'd0, wb_dest}, {28'd0, e.dest});
         chk("wb_data", {16'd0, wb_data}, {16'd0, e.data});
      end
      cls = ref_class(in_opcode);
      acc = (in_valid === 1'b1) && (mcount < 2);
      pop = (mcount != 0) && (out_ready === 1'b1);
      if (pop) void'(sb.pop_front());
      if (acc) begin
         e.we   = cls[5];
         e.dest = in_dest;
         e.data = cls[5] ? in_result : 16'h0000;
         sb.push_back(e);
      end
      mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (psr_wr_en) mpsr = psr_wr_data;
      else if (acc)  mpsr = (mpsr & ~cls[4:0]) | (in_flags & cls[4:0]);
      @(posedge clk);
      #1;
   endtask

   initial begin
      ops = '{OP_ADDU, OP_ADDCI, OP_SUB, OP_CMPU, OP_AND, OP_NOT,
              OP_LSH, OP_ARSHI, OP_NOP, 8'hFE, OP_ORI, OP_CMPI};
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      out_ready   = 1'b0;
      psr_wr_en   = 1'b0;
      psr_wr_data = 5'b00000;
      mcount      = 0;
      mpsr        = 5'b00000;
      #1 rst_n = 1'b0;
      #11;
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst psr", {27'd0, psr}, 32'd0);
      chk("rst carry", {31'd0, carry}, 32'd0);
      chk("rst wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst wb_dest", {28'd0, wb_dest}, 32'd0);
      chk("rst wb_data", {16'd0, wb_data}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADDU FFFF+0001 -> C=0000, carry and zero set
      out_ready = 1'b1;
      drive(1'b1, OP_ADDU, 16'h0000, 5'b11000, 4'd3);
      tick();
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      chk("addu psr", {27'd0, psr}, {27'd0, 5'b11000});
      chk("addu carry", {31'd0, carry}, 32'd1);
      chk("addu out_valid", {31'd0, out_valid}, 32'd1);
      chk("addu wb_we", {31'd0, wb_we}, 32'd1);
      chk("addu wb_data", {16'd0, wb_data}, 32'd0);
      tick();

      // CMP keeps carry, updates N/L/Z
      psr_wr_en   = 1'b1;
      psr_wr_data = 5'b01000;
      tick();
      psr_wr_en = 1'b0;
      drive(1'b1, OP_CMP, 16'h1234, 5'b00011, 4'd5);
      tick();
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      chk("cmp psr", {27'd0, psr}, {27'd0, 5'b01011});
      chk("cmp out_valid", {31'd0, out_valid}, 32'd1);
      chk("cmp wb_we", {31'd0, wb_we}, 32'd0);
      tick();

      // Stall writeback, fill, and have the third push refused
      out_ready = 1'b0;
      drive(1'b1, OP_ADD, 16'h00AA, 5'b10100, 4'd1);
      tick();
      drive(1'b1, OP_XOR, 16'h0F0F, 5'b00000, 4'd2);
      tick();
      drive(1'b1, OP_SUB, 16'hBEEF, 5'b10000, 4'd4);
      hold = mpsr;
      chk("full in_ready", {31'd0, in_ready}, 32'd0);
      chk("full psr before", {27'd0, psr}, {27'd0, 5'b01111});
      tick();
      tick();
      chk("full psr hold", {27'd0, psr}, {27'd0, hold});
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      out_ready = 1'b1;
      chk("drain first dest", {28'd0, wb_dest}, 32'd1);
      tick();
      chk("drain second dest", {28'd0, wb_dest}, 32'd2);
      chk("drain second data", {16'd0, wb_data}, 32'h0F0F);
      tick();
      chk("drained", {31'd0, out_valid}, 32'd0);

      // Explicit PSR load beats the accept-cycle mask update
      psr_wr_en   = 1'b1;
      psr_wr_data = 5'b00100;
      drive(1'b1, OP_AND, 16'h5555, 5'b10000, 4'd6);
      tick();
      psr_wr_en = 1'b0;
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      chk("wr psr", {27'd0, psr}, {27'd0, 5'b00100});
      chk("wr out_valid", {31'd0, out_valid}, 32'd1);
      chk("wr wb_data", {16'd0, wb_data}, 32'h5555);
      tick();

      // NOP with unknown result, then an unlisted opcode
      hold = mpsr;
      drive(1'b1, OP_NOP, 16'hxxxx, 5'bxxxxx, 4'd7);
      tick();
      drive(1'b1, 8'hFE, 16'h1234, 5'b11111, 4'd8);
      chk("nop wb_we", {31'd0, wb_we}, 32'd0);
      chk("nop wb_data", {16'd0, wb_data}, 32'd0);
      chk("nop psr", {27'd0, psr}, {27'd0, hold});
      tick();
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      chk("unk wb_data", {16'd0, wb_data}, 32'd0);
      chk("unk psr", {27'd0, psr}, {27'd0, hold});
      tick();

      // Reset with both entries occupied
      out_ready = 1'b0;
      drive(1'b1, OP_ADDU, 16'h7777, 5'b11000, 4'd9);
      tick();
      drive(1'b1, OP_OR, 16'h8888, 5'b00000, 4'd10);
      tick();
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      chk("pre-rst full", {31'd0, in_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst psr", {27'd0, psr}, 32'd0);
      chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst carry", {31'd0, carry}, 32'd0);
      sb.delete();
      mcount = 0;
      mpsr   = 5'b00000;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mixed traffic with random back-pressure and occasional PSR loads
      for (int i = 0; i < 80; i++) begin
         out_ready   = 1'($urandom_range(0, 3) != 0);
         psr_wr_en   = 1'($urandom_range(0, 7) == 0);
         psr_wr_data = 5'($urandom);
         drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 11)],
               16'($urandom), 5'($urandom), 4'($urandom));
         tick();
      end
      psr_wr_en = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, OP_NOP, 16'h0000, 5'b00000, 4'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("final empty", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
